// File: rtl/fp_addsub_pipe_if.sv
// Handshake and operand/result bundle for the pipelined FP add/sub unit.
// The upstream operand source and the downstream result consumer share one
// bundle; "master" is the environment side and "slave" is the unit itself.
// Optional macro FP_FLAGS_EN adds the o_flags status vector.
interface fp_addsub_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   // Operand side
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_src1;
   logic [W-1:0] i_src2;
   logic         i_op;

   // Result side
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_result;
   logic         o_exception;
`ifdef FP_FLAGS_EN
   logic [3:0]   o_flags;

   modport master (
      output i_valid, i_src1, i_src2, i_op, i_ready,
      input  o_ready, o_valid, o_result, o_exception, o_flags
   );

   modport slave (
      input  i_valid, i_src1, i_src2, i_op, i_ready,
      output o_ready, o_valid, o_result, o_exception, o_flags
   );
`else
   modport master (
      output i_valid, i_src1, i_src2, i_op, i_ready,
      input  o_ready, o_valid, o_result, o_exception
   );

   modport slave (
      input  i_valid, i_src1, i_src2, i_op, i_ready,
      output o_ready, o_valid, o_result, o_exception
   );
`endif
endinterface

// File: rtl/fp_addsub_pipe.sv
// Parametrised 3-stage pipelined IEEE-754 adder/subtractor.
//   Stage 1: operand ordering and alignment of the smaller significand.
//   Stage 2: significand add/subtract and normalisation (subnormal aware).
//   Stage 3: round-to-nearest-even, overflow to infinity, packing.
// A single advance signal stalls every stage together when the result is
// held by the consumer. Any operand with an all-ones exponent yields the
// canonical quiet NaN with o_exception set.
// Optional macro FP_FLAGS_EN adds o_flags = {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   fp_addsub_pipe_if.slave bus
);
   localparam int W = 1 + EXP_W + MAN_W;
   // Working significand: {hidden, fraction, guard, round, sticky}
   localparam int F = MAN_W + 4;

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // ------------------------------------------------------------------
   // Global flow control
   // ------------------------------------------------------------------
   logic advance;

   assign advance     = !bus.o_valid || bus.i_ready;
   assign bus.o_ready = advance;

   // ------------------------------------------------------------------
   // Stage 1: order operands by magnitude and align the smaller one
   // ------------------------------------------------------------------
   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] frac_a, frac_b;

   assign {sign_a, exp_a, frac_a} = bus.i_src1;
   assign {sign_b, exp_b, frac_b} = bus.i_src2;

   logic             sign_b_eff, sub_eff, a_ge_b, special_in, sign_big;
   logic [EXP_W-1:0] exp_big, exp_small, e_big, e_small, diff;
   logic [MAN_W-1:0] frac_big, frac_small;
   logic [F-1:0]     big_sig, small_sig, aligned;
   logic [2*F-1:0]   wide;
   logic [31:0]      shift_amt;

   // Decode, compare and align the incoming operand pair.
   always_comb begin
      // NOTE: every variable gets a value on every path through this block,
      // so no latch can be inferred for it.
      sign_b_eff = sign_b ^ bus.i_op;
      sub_eff    = sign_a ^ sign_b_eff;
      special_in = (exp_a == EXP_ONES) || (exp_b == EXP_ONES);
      a_ge_b     = {exp_a, frac_a} >= {exp_b, frac_b};

      if (a_ge_b) begin
         sign_big   = sign_a;
         exp_big    = exp_a;
         frac_big   = frac_a;
         exp_small  = exp_b;
         frac_small = frac_b;
      end else begin
         sign_big   = sign_b_eff;
         exp_big    = exp_b;
         frac_big   = frac_b;
         exp_small  = exp_a;
         frac_small = frac_a;
      end

      // Subnormals behave as exponent 1 with a zero hidden bit.
      e_big     = (exp_big   == '0) ? EXP_ONE : exp_big;
      e_small   = (exp_small == '0) ? EXP_ONE : exp_small;
      diff      = e_big - e_small;
      big_sig   = {exp_big   != '0, frac_big,   3'b000};
      small_sig = {exp_small != '0, frac_small, 3'b000};

      // Shifting by F already pushes everything into the sticky half, so
      // larger distances are clamped there.
      shift_amt = (32'(diff) > 32'(F)) ? 32'(F) : 32'(diff);
      wide      = {small_sig, {F{1'b0}}} >> shift_amt;
      aligned   = wide[2*F-1:F] | {{(F-1){1'b0}}, |wide[F-1:0]};
   end

   logic             s1_valid, s1_special, s1_sub, s1_sign;
   logic [EXP_W-1:0] s1_exp;
   logic [F-1:0]     s1_big, s1_small;

   // Stage 1 register: capture the ordered, aligned operands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: flops are written with non-blocking assignments so every
      // stage samples the previous stage's old value on the same edge.
      if (!i_rst_n) begin
         s1_valid   <= 1'b0;
         s1_special <= 1'b0;
         s1_sub     <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_big     <= '0;
         s1_small   <= '0;
      end else if (advance) begin
         s1_valid   <= bus.i_valid;
         s1_special <= special_in;
         s1_sub     <= sub_eff;
         s1_sign    <= sign_big;
         s1_exp     <= e_big;
         s1_big     <= big_sig;
         s1_small   <= aligned;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: add/subtract and normalise
   // ------------------------------------------------------------------
   logic [F:0]       sum;
   logic [F-1:0]     norm;
   logic [EXP_W-1:0] exp_norm, max_shl;
   logic [31:0]      lzc, shl;
   logic             sign_norm;

   // Combine significands, then renormalise without going below exponent 1.
   always_comb begin
      sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                   : ({1'b0, s1_big} + {1'b0, s1_small});

      // Leading-zero count of the F-bit field; the highest set bit wins.
      lzc = 32'(F);
      for (int i = 0; i < F; i++) begin
         if (sum[i]) lzc = 32'(F - 1 - i);
      end

      max_shl = s1_exp - EXP_ONE;
      shl     = (lzc < 32'(max_shl)) ? lzc : 32'(max_shl);

      if (sum[F]) begin
         norm     = {sum[F:2], sum[1] | sum[0]};
         exp_norm = s1_exp + EXP_ONE;
      end else begin
         norm     = sum[F-1:0] << shl;
         // A clamped shift leaves the hidden bit clear: the result is subnormal.
         exp_norm = norm[F-1] ? (s1_exp - shl[EXP_W-1:0]) : '0;
      end

      // Exact cancellation gives +0; like-signed zeros keep their sign.
      sign_norm = (s1_sub && (sum == '0)) ? 1'b0 : s1_sign;
   end

   logic             s2_valid, s2_special, s2_sign;
   logic [EXP_W-1:0] s2_exp;
   logic [F-1:0]     s2_man;

   // Stage 2 register: capture the normalised significand and exponent.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid   <= 1'b0;
         s2_special <= 1'b0;
         s2_sign    <= 1'b0;
         s2_exp     <= '0;
         s2_man     <= '0;
      end else if (advance) begin
         s2_valid   <= s1_valid;
         s2_special <= s1_special;
         s2_sign    <= sign_norm;
         s2_exp     <= exp_norm;
         s2_man     <= norm;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: round to nearest even and pack
   // ------------------------------------------------------------------
   logic [MAN_W:0]   keep;
   logic [MAN_W+1:0] rnd;
   logic [EXP_W:0]   exp_rnd;
   logic [MAN_W-1:0] frac_rnd;
   logic             inc, ovf, grs;
   logic [W-1:0]     result_n;
   logic             exc_n;

   // Apply RNE, propagate mantissa carry into the exponent, detect overflow.
   always_comb begin
      keep = s2_man[F-1:3];
      grs  = |s2_man[2:0];
      inc  = s2_man[2] & (s2_man[1] | s2_man[0] | keep[0]);
      rnd  = {1'b0, keep} + {{(MAN_W+1){1'b0}}, inc};

      exp_rnd  = {1'b0, s2_exp};
      frac_rnd = rnd[MAN_W-1:0];
      if (rnd[MAN_W+1]) begin
         exp_rnd  = exp_rnd + (EXP_W+1)'(1);
         frac_rnd = rnd[MAN_W:1];
      end else if ((s2_exp == '0) && rnd[MAN_W]) begin
         // Largest subnormal rounded up into the smallest normal.
         exp_rnd = (EXP_W+1)'(1);
      end

      ovf = exp_rnd >= {1'b0, EXP_ONES};

      if (s2_special) begin
         result_n = QNAN;
         exc_n    = 1'b1;
      end else if (ovf) begin
         result_n = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
         exc_n    = 1'b1;
      end else begin
         result_n = {s2_sign, exp_rnd[EXP_W-1:0], frac_rnd};
         exc_n    = 1'b0;
      end
   end

`ifdef FP_FLAGS_EN
   logic       s1_invalid, s2_invalid;
   logic [3:0] flags_n;
   logic       invalid_in, nan_a, nan_b, inf_a, inf_b;

   // Classify invalid operations (any NaN, or Inf minus Inf).
   always_comb begin
      nan_a      = (exp_a == EXP_ONES) && (frac_a != '0);
      nan_b      = (exp_b == EXP_ONES) && (frac_b != '0);
      inf_a      = (exp_a == EXP_ONES) && (frac_a == '0);
      inf_b      = (exp_b == EXP_ONES) && (frac_b == '0);
      invalid_in = nan_a || nan_b || (inf_a && inf_b && sub_eff);
   end

   // Carry the invalid indication alongside the data through stages 1 and 2.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_invalid <= 1'b0;
         s2_invalid <= 1'b0;
      end else if (advance) begin
         s1_invalid <= invalid_in;
         s2_invalid <= s1_invalid;
      end
   end

   // Assemble {invalid, overflow, underflow, inexact} for the result beat.
   always_comb begin
      flags_n = 4'b0000;
      if (s2_special) begin
         flags_n[3] = s2_invalid;
      end else begin
         flags_n[2] = ovf;
         flags_n[0] = grs | ovf;
         flags_n[1] = (s2_exp == '0) && grs;
      end
   end
`endif

   // Output register: load a new result only when the consumer lets the pipe move.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_valid     <= 1'b0;
         bus.o_result    <= '0;
         bus.o_exception <= 1'b0;
`ifdef FP_FLAGS_EN
         bus.o_flags     <= 4'b0000;
`endif
      end else if (advance) begin
         bus.o_valid     <= s2_valid;
         bus.o_result    <= result_n;
         bus.o_exception <= exc_n;
`ifdef FP_FLAGS_EN
         bus.o_flags     <= flags_n;
`endif
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (binary32 configuration).
// Directed cases carry their expected words; random cases are predicted by
// an exact-arithmetic model: operands become integers in units of 2^-149,
// are summed exactly, and the sum is rounded to nearest-even.
module tb_fp_addsub_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   always #5 i_clk = ~i_clk;

   fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic        fixed;
      logic [31:0] res;
      logic        exc;
   } beat_t;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   beat_t stim_q[$];
   exp_t  sb_q[$];
   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Exact value of a finite operand in units of 2^-149.
   function automatic logic [299:0] mag_of(input logic [31:0] x);
      logic [299:0] m;
      if (x[30:23] == 8'h00) begin
         m = 300'(x[22:0]);
      end else begin
         m = 300'({1'b1, x[22:0]});
         m = m << (int'(x[30:23]) - 1);
      end
      return m;
   endfunction

   // Reference: returns {exception, result}.
   function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic op);
      logic [299:0] ma, mb, mag, keep, rem, half;
      logic         sa, sb, sr;
      int           p, sh, e;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC00000};
      sa = a[31];
      sb = b[31] ^ op;
      ma = mag_of(a);
      mb = mag_of(b);
      if (sa == sb) begin
         mag = ma + mb;
         sr  = sa;
      end else if (ma >= mb) begin
         mag = ma - mb;
         sr  = sa;
      end else begin
         mag = mb - ma;
         sr  = sb;
      end
      if (mag == '0) return {1'b0, (sa == sb) ? sa : 1'b0, 31'd0};
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      if (p < 23) return {1'b0, sr, 8'h00, mag[22:0]};
      sh   = p - 23;
      keep = mag >> sh;
      if (sh > 0) begin
         rem  = mag & ((300'd1 << sh) - 300'd1);
         half = 300'd1 << (sh - 1);
         if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
      end
      if (keep[24]) begin
         keep = keep >> 1;
         sh   = sh + 1;
      end
      e = sh + 1;
      if (e >= 255) return {1'b1, sr, 8'hFF, 23'd0};
      return {1'b0, sr, 8'(e), keep[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] x;
      int          k;
      x = $urandom;
      k = $urandom_range(0, 19);
      case (k)
         0, 1:    x[30:23] = 8'h00;
         2:       x[30:23] = 8'hFF;
         3, 4:    x[30:23] = 8'hFE;
         5:       x[30:23] = 8'h01;
         default: x[30:23] = 8'($urandom_range(100, 154));
      endcase
      return x;
   endfunction

   task automatic add_beat(input logic [31:0] a, input logic [31:0] b, input logic op);
      beat_t bt;
      bt.a = a; bt.b = b; bt.op = op; bt.fixed = 1'b0; bt.res = '0; bt.exc = 1'b0;
      stim_q.push_back(bt);
   endtask

   task automatic add_fixed(input logic [31:0] a, input logic [31:0] b, input logic op,
                            input logic [31:0] res, input logic exc);
      beat_t bt;
      bt.a = a; bt.b = b; bt.op = op; bt.fixed = 1'b1; bt.res = res; bt.exc = exc;
      stim_q.push_back(bt);
   endtask

   task automatic add_random(input int count);
      logic [31:0] a, b;
      int          e;
      for (int i = 0; i < count; i++) begin
         a = rand_fp();
         case ($urandom_range(0, 3))
            0: b = rand_fp();
            1: begin
               b = $urandom;
               e = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
               if (e < 0) e = 0;
               if (e > 254) e = 254;
               b[30:23] = 8'(e);
            end
            2: b = {$urandom_range(0, 1) == 1, a[30:0]};
            default: begin
               b = a;
               b[2:0] = 3'($urandom);
            end
         endcase
         add_beat(a, b, 1'($urandom));
      end
   endtask

   // Drive queued beats and score every output cycle.
   // mode 0: always ready (latency checked), 1: ready 1,0,0 pattern,
   // 2: random ready and random input gaps.
   task automatic run_stream(input int mode, input int budget);
      int          n;
      logic        presenting;
      logic [32:0] m;
      exp_t        ex;
      n          = 0;
      presenting = 1'b0;
      while ((stim_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
         @(negedge i_clk);
         cyc++;
         n++;
         case (mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = (n % 3 == 1);
            default: bus.i_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (!presenting && stim_q.size() != 0)
            presenting = (mode != 2) || ($urandom_range(0, 3) != 0);
         bus.i_valid = presenting;
         if (presenting) begin
            bus.i_src1 = stim_q[0].a;
            bus.i_src2 = stim_q[0].b;
            bus.i_op   = stim_q[0].op;
         end
         #1;
         check("o_ready", bus.o_ready, !bus.o_valid || bus.i_ready);
         if (bus.o_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", bus.o_valid, 1'b0);
            end else begin
               check("result", bus.o_result, sb_q[0].res);
               check("exception", bus.o_exception, sb_q[0].exc);
               if (bus.i_ready) begin
                  if (mode == 0) check("latency", cyc - sb_q[0].cyc, 3);
                  void'(sb_q.pop_front());
               end
            end
         end
         if (presenting && bus.o_ready) begin
            if (stim_q[0].fixed) begin
               ex.res = stim_q[0].res;
               ex.exc = stim_q[0].exc;
            end else begin
               m      = model_add(stim_q[0].a, stim_q[0].b, stim_q[0].op);
               ex.res = m[31:0];
               ex.exc = m[32];
            end
            ex.cyc = cyc;
            sb_q.push_back(ex);
            void'(stim_q.pop_front());
            presenting = 1'b0;
         end
      end
      if (n >= budget) begin
         check("stream_timeout", 64'(stim_q.size() + sb_q.size()), 0);
         @(negedge i_clk);
         bus.i_valid = 1'b0;
         stim_q.delete();
         sb_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [32:0] m;
      logic [31:0] fa;
      bus.i_valid = 1'b0;
      bus.i_src1  = '0;
      bus.i_src2  = '0;
      bus.i_op    = 1'b0;
      bus.i_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge i_clk);
      #1;
      check("reset_valid", bus.o_valid, 1'b0);
      check("reset_result", bus.o_result, 32'h0);
      check("reset_exception", bus.o_exception, 1'b0);
      i_rst_n = 1'b1;

      // Basic add, zeros, RNE ties, subnormals, overflow
      add_fixed(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
      add_fixed(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
      add_fixed(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0);
      add_fixed(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0);
      add_fixed(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0);
      add_fixed(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0);
      add_fixed(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0);
      add_fixed(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0);
      add_fixed(32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 1'b0);
      add_fixed(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);
      add_fixed(32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1);
      add_fixed(32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1);
      run_stream(0, 200);

      // Back-to-back stream of 8 beats under a 1,0,0 ready pattern
      add_random(8);
      run_stream(1, 200);

      // Reset with three beats in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         cyc++;
         fa          = rand_fp();
         bus.i_ready = 1'b1;
         bus.i_valid = 1'b1;
         bus.i_src1  = fa;
         bus.i_src2  = 32'h3F800000;
         bus.i_op    = 1'b0;
         if (k == 0) m = model_add(fa, 32'h3F800000, 1'b0);
      end
      @(negedge i_clk);
      cyc++;
      bus.i_valid = 1'b0;
      #1;
      check("pre_reset_valid", bus.o_valid, 1'b1);
      check("pre_reset_result", bus.o_result, m[31:0]);
      i_rst_n = 1'b0;
      #1;
      check("mid_reset_valid", bus.o_valid, 1'b0);
      check("mid_reset_result", bus.o_result, 32'h0);
      check("mid_reset_exception", bus.o_exception, 1'b0);
      @(negedge i_clk);
      cyc++;
      i_rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge i_clk);
         cyc++;
         #1;
         check("post_reset_stale", bus.o_valid, 1'b0);
      end
      add_fixed(32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1);
      run_stream(0, 50);

      // Randomised traffic against the exact-arithmetic model
      add_random(200);
      run_stream(2, 3000);
      add_random(100);
      run_stream(0, 1000);

      repeat (3) @(negedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
